// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package inst_loader_pkg;

    localparam int DEF_ADDR_W    = 10;
    localparam int DEF_WORD_W    = 32;
    localparam int DEF_MAX_WORDS = 1024;

    // Frame layout: count bytes, then WORD_BYTES per word, then one checksum byte.
    localparam int CNT_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_BYTES = 1;

    typedef enum logic [2:0] {
        CNT_HI = 3'd0,
        CNT_LO = 3'd1,
        WORD   = 3'd2,
        CSUM   = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } ld_state_t;

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects bytes MSB first into an instruction word; strobes word_valid the
// cycle after the last byte of a word is taken.
module word_assembler
    import inst_loader_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_last,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data
);

    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    logic [WORD_W-1:0] shift_r;
    logic [1:0]        byte_idx_r;
    logic              word_valid_r;

    assign word_last  = byte_valid && (byte_idx_r == LAST_BYTE);
    assign word_valid = word_valid_r;
    assign word_data  = shift_r;

    // Shift register, byte position within the word, and the one-cycle word strobe.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shift_r      <= {WORD_W{1'b0}};
            byte_idx_r   <= 2'd0;
            word_valid_r <= 1'b0;
        end else if (clr) begin
            shift_r      <= {WORD_W{1'b0}};
            byte_idx_r   <= 2'd0;
            word_valid_r <= 1'b0;
        end else begin
            word_valid_r <= word_last;
            if (byte_valid) begin
                shift_r    <= {shift_r[WORD_W-9:0], byte_data};
                byte_idx_r <= byte_idx_r + 2'd1;
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: parses a length-prefixed, checksummed byte frame and writes the
// words into instruction memory, holding the CPU until a good frame completes.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              err
);

    localparam logic [ADDR_W:0] IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [15:0]     MAX_CNT   = 16'(MAX_WORDS);

    ld_state_t         state_r;
    ld_state_t         next_s;
    logic [7:0]        cnt_hi_r;
    logic [15:0]       word_cnt_r;
    logic [ADDR_W:0]   word_idx_r;
    logic [7:0]        sum_r;
    logic [ADDR_W-1:0] imem_addr_r;

    logic              rx_ready_s;
    logic              acc_s;
    logic              restart_s;
    logic [15:0]       count_s;
    logic              count_ok_s;
    logic [16:0]       idx_next_s;
    logic              last_word_s;
    logic              word_last_s;

    assign rx_ready_s  = (state_r == CNT_HI) || (state_r == CNT_LO) ||
                         (state_r == WORD)   || (state_r == CSUM);
    assign acc_s       = rx_valid && rx_ready_s;
    assign restart_s   = start && ((state_r == DONE) || (state_r == ERROR));
    assign count_s     = {cnt_hi_r, rx_data};
    assign count_ok_s  = (count_s != 16'd0) && (count_s <= MAX_CNT);
    // Index is one bit wider than the address so a full 1024-word image ends cleanly.
    assign idx_next_s  = 17'(word_idx_r) + 17'd1;
    assign last_word_s = (idx_next_s == {1'b0, word_cnt_r});

    word_assembler #(
        .WORD_W (WORD_W)
    ) u_asm (
        .clock      (clock),
        .reset_n    (reset_n),
        .clr        (restart_s),
        .byte_valid (acc_s && (state_r == WORD)),
        .byte_data  (rx_data),
        .word_last  (word_last_s),
        .word_valid (imem_we),
        .word_data  (imem_wdata)
    );

    // Frame state register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r <= CNT_HI;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            CNT_HI: begin
                if (acc_s) next_s = CNT_LO;
                else       next_s = state_r;
            end
            CNT_LO: begin
                if (acc_s) next_s = count_ok_s ? WORD : ERROR;
                else       next_s = state_r;
            end
            WORD: begin
                if (word_last_s && last_word_s) next_s = CSUM;
                else                            next_s = state_r;
            end
            CSUM: begin
                if (acc_s) next_s = (rx_data == sum_r) ? DONE : ERROR;
                else       next_s = state_r;
            end
            DONE, ERROR: begin
                if (start) next_s = CNT_HI;
                else       next_s = state_r;
            end
            default: next_s = CNT_HI;
        endcase
    end

    // Word count, word index, running checksum and write address.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_hi_r    <= 8'd0;
            word_cnt_r  <= 16'd0;
            word_idx_r  <= {(ADDR_W+1){1'b0}};
            sum_r       <= 8'd0;
            imem_addr_r <= {ADDR_W{1'b0}};
        end else if (restart_s) begin
            cnt_hi_r    <= 8'd0;
            word_cnt_r  <= 16'd0;
            word_idx_r  <= {(ADDR_W+1){1'b0}};
            sum_r       <= 8'd0;
        end else begin
            if (acc_s && (state_r != CSUM)) begin
                sum_r <= csum_add(sum_r, rx_data);
            end
            if (acc_s && (state_r == CNT_HI)) begin
                cnt_hi_r <= rx_data;
            end
            if (acc_s && (state_r == CNT_LO)) begin
                word_cnt_r <= count_s;
            end
            if (word_last_s) begin
                imem_addr_r <= word_idx_r[ADDR_W-1:0];
                word_idx_r  <= word_idx_r + IDX_ONE;
            end
        end
    end

    assign rx_ready  = rx_ready_s;
    assign imem_addr = imem_addr_r;
    assign cpu_hold  = (state_r != DONE);
    assign load_done = (state_r == DONE);
    assign err       = (state_r == ERROR);

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: frames, checksum and count errors, restart and reset.
module tb_inst_loader;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_valid = 1'b0;
    logic        start    = 1'b0;
    logic        rx_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        err;

    int checks  = 0;
    int errors  = 0;
    int wr_cnt  = 0;
    int rdy_bad = 0;
    int base    = 0;
    logic [9:0]  log_addr [0:2047];
    logic [31:0] log_data [0:2047];
    logic [31:0] w3 [0:2];
    logic [31:0] w;
    logic [7:0]  sum;

    inst_loader dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .start      (start),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .err        (err)
    );

    always #5 clock = ~clock;

    // Log every write strobe, sampled mid-cycle.
    always @(negedge clock) begin
        if (imem_we === 1'b1 && wr_cnt < 2048) begin
            log_addr[wr_cnt] <= imem_addr;
            log_data[wr_cnt] <= imem_wdata;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        if (rx_ready !== 1'b1) rdy_bad++;
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [31:0] wd);
        for (int k = 3; k >= 0; k--) send(wd[8*k +: 8]);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"},  32'(rx_ready),   32'd1);
        chk({tag, "_imem_we"},   32'(imem_we),    32'd0);
        chk({tag, "_imem_addr"}, 32'(imem_addr),  32'd0);
        chk({tag, "_imem_wd"},   imem_wdata,      32'd0);
        chk({tag, "_cpu_hold"},  32'(cpu_hold),   32'd1);
        chk({tag, "_load_done"}, 32'(load_done),  32'd0);
        chk({tag, "_err"},       32'(err),        32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk_reset_vals("rst");
        reset_n = 1'b1;

        // Single-word frame, back-to-back bytes
        base = wr_cnt;
        send(8'h00); send(8'h01); send_word(32'h20080005); send(8'h2E);
        rx_valid = 1'b0;
        chk("f1_load_done", 32'(load_done), 32'd1);
        chk("f1_cpu_hold",  32'(cpu_hold),  32'd0);
        chk("f1_err",       32'(err),       32'd0);
        chk("f1_rx_ready",  32'(rx_ready),  32'd0);
        chk("f1_nwr",       32'(wr_cnt - base), 32'd1);
        chk("f1_addr",      32'(log_addr[base]), 32'd0);
        chk("f1_data",      log_data[base], 32'h20080005);
        idle(3);
        chk("f1_no_extra",  32'(wr_cnt - base), 32'd1);

        // Restart from DONE
        pulse_start();
        chk("st_cpu_hold",  32'(cpu_hold),  32'd1);
        chk("st_load_done", 32'(load_done), 32'd0);
        chk("st_rx_ready",  32'(rx_ready),  32'd1);

        // Three words with idle gaps; start mid-frame must be ignored
        w3[0] = 32'h01020304; w3[1] = 32'hA5B6C7D8; w3[2] = 32'hFFFF0000;
        base = wr_cnt;
        rdy_bad = 0;
        send(8'h00); idle($urandom_range(0, 3));
        send(8'h03); idle($urandom_range(0, 3));
        for (int i = 0; i < 3; i++) begin
            for (int k = 3; k >= 0; k--) begin
                send(w3[i][8*k +: 8]);
                idle($urandom_range(0, 3));
            end
            if (i == 0) begin
                pulse_start();
                chk("f2_start_ign_hold",  32'(cpu_hold), 32'd1);
                chk("f2_start_ign_ready", 32'(rx_ready), 32'd1);
            end
        end
        send(8'h05);
        rx_valid = 1'b0;
        chk("f2_load_done", 32'(load_done), 32'd1);
        chk("f2_cpu_hold",  32'(cpu_hold),  32'd0);
        chk("f2_rdy_held",  32'(rdy_bad),   32'd0);
        chk("f2_nwr",       32'(wr_cnt - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("f2_addr", 32'(log_addr[base + i]), 32'(i));
            chk("f2_data", log_data[base + i], w3[i]);
        end

        // Checksum off by one
        pulse_start();
        base = wr_cnt;
        send(8'h00); send(8'h02);
        send_word(32'h11223344); send_word(32'h55667788);
        send(8'h67);
        rx_valid = 1'b0;
        chk("f3_err",       32'(err),       32'd1);
        chk("f3_load_done", 32'(load_done), 32'd0);
        chk("f3_cpu_hold",  32'(cpu_hold),  32'd1);
        chk("f3_rx_ready",  32'(rx_ready),  32'd0);
        chk("f3_nwr",       32'(wr_cnt - base), 32'd2);
        chk("f3_data1",     log_data[base + 1], 32'h55667788);

        // Zero count
        pulse_start();
        chk("rearm_err", 32'(err), 32'd0);
        base = wr_cnt;
        send(8'h00); send(8'h00);
        rx_valid = 1'b0;
        chk("cnt0_err",      32'(err),      32'd1);
        chk("cnt0_rx_ready", 32'(rx_ready), 32'd0);
        idle(2);
        chk("cnt0_nwr",      32'(wr_cnt - base), 32'd0);

        // Count one above the maximum
        pulse_start();
        base = wr_cnt;
        send(8'h04); send(8'h01);
        rx_valid = 1'b0;
        chk("cnt1025_err",  32'(err),      32'd1);
        chk("cnt1025_hold", 32'(cpu_hold), 32'd1);
        idle(2);
        chk("cnt1025_nwr",  32'(wr_cnt - base), 32'd0);

        // Maximum count: 1024 words
        pulse_start();
        base = wr_cnt;
        sum = 8'h04;
        send(8'h04); send(8'h00);
        for (int i = 0; i < 1024; i++) begin
            w = 32'hC0DE0000 | 32'(i);
            sum = sum + w[31:24] + w[23:16] + w[15:8] + w[7:0];
            send_word(w);
        end
        send(sum);
        rx_valid = 1'b0;
        chk("max_load_done", 32'(load_done), 32'd1);
        chk("max_err",       32'(err),       32'd0);
        chk("max_nwr",       32'(wr_cnt - base), 32'd1024);
        chk("max_first",     32'(log_addr[base]), 32'd0);
        chk("max_last_addr", 32'(log_addr[base + 1023]), 32'd1023);
        chk("max_last_data", log_data[base + 1023], 32'hC0DE03FF);

        // Reset during byte 2 of word 1
        pulse_start();
        send(8'h00); send(8'h02);
        send_word(32'hDEADBEEF);
        send(8'h12);
        rx_data  = 8'h34;
        rx_valid = 1'b1;
        reset_n  = 1'b0;
        @(posedge clock);
        #1;
        reset_n  = 1'b1;
        rx_valid = 1'b0;
        chk_reset_vals("midrst");

        // Fresh frame after reset loads from address 0
        base = wr_cnt;
        send(8'h00); send(8'h01); send_word(32'h20080005); send(8'h2E);
        rx_valid = 1'b0;
        chk("f5_load_done", 32'(load_done), 32'd1);
        chk("f5_nwr",       32'(wr_cnt - base), 32'd1);
        chk("f5_addr",      32'(log_addr[base]), 32'd0);
        chk("f5_data",      log_data[base], 32'h20080005);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
